// File: rtl/lc3_pipe_ctrl_if.sv
// Handshake bundle between the LC3 pipeline control unit (master) and the datapath/memories (slave).
// The master drives the stage enables and status; the slave drives the instruction, memory-ready and branch inputs.
interface lc3_pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [15:0]      IR_exec;
    logic             imem_ready;
    logic             dmem_ready;
    logic             br_taken;
    logic             enable_updatePC;
    logic             enable_fetch;
    logic             enable_decode;
    logic             enable_execute;
    logic             enable_writeback;
    logic [1:0]       mem_state;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, IR_exec, imem_ready, dmem_ready, br_taken,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, mem_state, halted, err, retired
    );

    modport slave (
        output start, IR_exec, imem_ready, dmem_ready, br_taken,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, mem_state, halted, err, retired
    );
endinterface

// File: rtl/lc3_pipe_ctrl.sv
// Purpose: LC3 pipeline control -- stage enables, dmem sequencing (incl. LDI/STI pointer read), flush, halt, retire count.
// Latency: enables/mem_state combinational from state + imem_ready + opcode; halted/err/retired registered (1 cycle).
// Backpressure: imem_ready=0 freezes RUN and pauses FLUSH; dmem_ready=0 holds MEM states until DMEM_TIMEOUT aborts.
module lc3_pipe_ctrl #(
    parameter int BR_FLUSH     = 2,
    parameter int DMEM_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input logic              clk,
    input logic              rst,
    lc3_pipe_ctrl_if.master  bus
);
    localparam int TO_W = $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_MEM_IND, S_MEM_RW, S_FLUSH, S_HALT
    } state_t;

    state_t           state_q, next_state;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       fl_cnt;
    logic             op_store;
    logic             halted_q, err_q;
    logic [CNT_W-1:0] retired_q;

    logic [3:0] opc;
    logic is_ldst, is_ind, is_st, is_ctl, is_trap, in_mem, timeout;
    logic en_upd, en_fet, en_dec, en_exe, en_wb;
    logic [1:0] ms;

    always_comb begin
        opc     = bus.IR_exec[15:12];
        is_ldst = (opc == 4'b0010) || (opc == 4'b0110) || (opc == 4'b0011) || (opc == 4'b0111);
        is_ind  = (opc == 4'b1010) || (opc == 4'b1011);
        is_st   = (opc == 4'b0011) || (opc == 4'b0111) || (opc == 4'b1011);
        is_ctl  = (opc == 4'b0000) || (opc == 4'b1100);
        is_trap = (opc == 4'b1111);
        in_mem  = (state_q == S_MEM_IND) || (state_q == S_MEM_RW);
        // Last allowed wait cycle still lets a late dmem_ready complete the access.
        timeout = in_mem && (to_cnt == TO_W'(DMEM_TIMEOUT - 1)) && !bus.dmem_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE:    if (bus.start) next_state = S_RUN;
            S_RUN: begin
                if (bus.imem_ready) begin
                    if (is_ldst)                     next_state = S_MEM_RW;
                    else if (is_ind)                 next_state = S_MEM_IND;
                    else if (is_ctl && bus.br_taken) next_state = S_FLUSH;
                    else if (is_trap)                next_state = S_HALT;
                end
            end
            S_MEM_IND: begin
                if (bus.dmem_ready)   next_state = S_MEM_RW;
                else if (timeout)     next_state = S_RUN;
            end
            S_MEM_RW:  if (bus.dmem_ready || timeout) next_state = S_RUN;
            S_FLUSH:   if (bus.imem_ready && fl_cnt == 4'd1) next_state = S_RUN;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        en_upd = 1'b0;
        en_fet = 1'b0;
        en_dec = 1'b0;
        en_exe = 1'b0;
        en_wb  = 1'b0;
        ms     = 2'd3;
        case (state_q)
            S_RUN: begin
                if (bus.imem_ready) begin
                    en_upd = 1'b1;
                    en_fet = 1'b1;
                    en_dec = 1'b1;
                    en_exe = 1'b1;
                    en_wb  = !(is_ldst || is_ind);
                end
            end
            S_MEM_IND: ms = 2'd2;
            S_MEM_RW: begin
                ms    = op_store ? 2'd1 : 2'd0;
                en_wb = bus.dmem_ready && !op_store;
            end
            S_FLUSH: begin
                en_upd = bus.imem_ready;
                en_fet = bus.imem_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt   <= '0;
            fl_cnt   <= '0;
            op_store <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state_q != next_state) to_cnt <= '0;
            else if (in_mem)           to_cnt <= to_cnt + 1'b1;

            if (state_q == S_RUN && next_state == S_FLUSH)  fl_cnt <= 4'(BR_FLUSH);
            else if (state_q == S_FLUSH && bus.imem_ready)  fl_cnt <= fl_cnt - 4'd1;

            // IR_exec moves on during the access, so the direction is captured at issue.
            if (state_q == S_RUN && bus.imem_ready) op_store <= is_st;

            halted_q  <= (next_state == S_HALT);
            err_q     <= err_q || timeout;
            retired_q <= retired_q + CNT_W'(en_wb);
        end
    end

    assign bus.enable_updatePC  = en_upd;
    assign bus.enable_fetch     = en_fet;
    assign bus.enable_decode    = en_dec;
    assign bus.enable_execute   = en_exe;
    assign bus.enable_writeback = en_wb;
    assign bus.mem_state        = ms;
    assign bus.halted           = halted_q;
    assign bus.err              = err_q;
    assign bus.retired          = retired_q;
endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl: stimulus queues expected per-cycle outputs, a negedge monitor compares.
module tb_lc3_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lc3_pipe_ctrl_if #(.CNT_W(4)) bus ();

    lc3_pipe_ctrl #(.BR_FLUSH(2), .DMEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [15:0] ADD  = 16'h1042, LDR = 16'h6042, LD  = 16'h2005;
    localparam logic [15:0] ST   = 16'h3005, STI = 16'hB005, LDI = 16'hA005;
    localparam logic [15:0] BR   = 16'h0E05, JMP = 16'hC1C0, TRAP = 16'hF025;
    localparam logic [4:0]  ALL  = 5'b11111, NOWB = 5'b11110, NONE = 5'b00000;
    localparam logic [4:0]  WB   = 5'b00001, FL   = 5'b11000;

    typedef struct {
        int         id;
        logic [4:0] en;
        logic [1:0] ms;
        logic       h;
        logic       e;
        logic [3:0] ret;
    } exp_t;

    exp_t       q[$];
    exp_t       mx;
    int         checks = 0;
    int         failures = 0;
    int         vec = 0;
    logic [3:0] m_ret = 4'd0;
    logic [4:0] got_en;
    logic [5:0] got_st;

    initial begin
        bus.start = 1'b0; bus.IR_exec = ADD; bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0; bus.br_taken = 1'b0;
    end

    task automatic step(input logic r, input logic s, input logic [15:0] ir,
                        input logic im, input logic dm, input logic br,
                        input logic [4:0] en, input logic [1:0] ms,
                        input logic h, input logic e);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; bus.start = s; bus.IR_exec = ir;
        bus.imem_ready = im; bus.dmem_ready = dm; bus.br_taken = br;
        if (r) m_ret = 4'd0;
        x.id = vec; x.en = en; x.ms = ms; x.h = h; x.e = e; x.ret = m_ret;
        q.push_back(x);
        vec++;
        m_ret = m_ret + {3'b000, en[0]};
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mx = q.pop_front();
            got_en = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                      bus.enable_execute, bus.enable_writeback};
            got_st = {bus.halted, bus.err, bus.retired};
            checks++;
            if (got_en !== mx.en) begin
                failures++;
                $display("FAIL enables vec=%0d got=%b exp=%b", mx.id, got_en, mx.en);
            end
            checks++;
            if (bus.mem_state !== mx.ms) begin
                failures++;
                $display("FAIL mem_state vec=%0d got=%0d exp=%0d", mx.id, bus.mem_state, mx.ms);
            end
            checks++;
            if (got_st !== {mx.h, mx.e, mx.ret}) begin
                failures++;
                $display("FAIL status(halted,err,retired) vec=%0d got=%b exp=%b",
                         mx.id, got_st, {mx.h, mx.e, mx.ret});
            end
        end
    end

    initial begin
        // reset, IDLE ignores imem until start
        step(1, 0, ADD, 0, 0, 0, NONE, 3, 0, 0);
        step(1, 0, ADD, 0, 0, 0, NONE, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, NONE, 3, 0, 0);
        step(0, 1, ADD, 1, 0, 0, NONE, 3, 0, 0);
        // ALU stream
        for (int i = 0; i < 10; i++) step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 0);
        // LDR: three wait cycles then completion; IR_exec changes underneath
        step(0, 0, LDR, 1, 0, 0, NOWB, 3, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, ST, 1, 0, 0, NONE, 0, 0, 0);
        step(0, 0, ST, 1, 1, 0, WB, 0, 0, 0);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 0);
        // STI: pointer read then store
        step(0, 0, STI, 1, 0, 0, NOWB, 3, 0, 0);
        step(0, 0, LD, 1, 0, 0, NONE, 2, 0, 0);
        step(0, 0, LD, 1, 1, 0, NONE, 2, 0, 0);
        step(0, 0, LD, 1, 0, 0, NONE, 1, 0, 0);
        step(0, 0, LD, 1, 1, 0, NONE, 1, 0, 0);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 0);
        // taken BR, flush stalled one cycle by imem
        step(0, 0, BR, 1, 0, 1, ALL, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, FL, 3, 0, 0);
        step(0, 0, ADD, 0, 0, 0, NONE, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, FL, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 0);
        // br_taken ignored on non-branch, untaken BR, RUN stall ignores TRAP
        step(0, 0, ADD, 1, 0, 1, ALL, 3, 0, 0);
        step(0, 0, BR, 1, 0, 0, ALL, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 0);
        step(0, 0, TRAP, 0, 0, 0, NONE, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 0);
        // taken JMP
        step(0, 0, JMP, 1, 0, 1, ALL, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, FL, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, FL, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 0);
        // LD completing on the last cycle before timeout
        step(0, 0, LD, 1, 0, 0, NOWB, 3, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, LD, 1, 0, 0, NONE, 0, 0, 0);
        step(0, 0, LD, 1, 1, 0, WB, 0, 0, 0);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 0);
        // LD timing out after 15 cycles; err sticky
        step(0, 0, LD, 1, 0, 0, NOWB, 3, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, LD, 1, 0, 0, NONE, 0, 0, 0);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 1);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 1);
        // reset asserted mid-MEM_IND takes effect at once
        step(0, 0, LDI, 1, 0, 0, NOWB, 3, 0, 1);
        step(0, 0, LDI, 1, 0, 0, NONE, 2, 0, 1);
        step(1, 0, LDI, 1, 0, 0, NONE, 3, 0, 0);
        step(1, 0, LDI, 1, 0, 0, NONE, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, NONE, 3, 0, 0);
        step(0, 1, ADD, 1, 0, 0, NONE, 3, 0, 0);
        step(0, 0, ADD, 1, 0, 0, ALL, 3, 0, 0);
        // TRAP halts; start and other inputs ignored
        step(0, 0, TRAP, 1, 0, 0, ALL, 3, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, ADD, 1, 1, 1, NONE, 3, 1, 0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
